seq_det_event_mon: RTL and testbench
====================================

Name: seq_det_event_mon

Overview:
- Downstream consumer of the 1011 sequence detector's single-cycle match pulse.
- Keeps a saturating total match count and measures the spacing between consecutive matches.
- Raises a latched alert when the number of matches in a fixed observation window reaches a threshold.
- The alert is held until software or a controller acknowledges it.

Parameters:
- CNT_W, 8, width of the total match counter (saturating).
- GAP_W, 8, width of the inter-match gap measurement (saturating).
- WINDOW, 32, observation window length in clk cycles; legal range 2 to 2^16.
- THRESH, 4, matches per window that trigger an alert; legal range 1 to WINDOW.

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset; all state cleared while low.
- det_in  input  1  match pulse from detector output; one cycle high per match; back-to-back highs are legal.
- enable  input  1  monitoring enable; when low, block holds in IDLE.
- clear  input  1  synchronous clear of counters, gap state and alert.
- alert_ack  input  1  acknowledges a pending alert.
- match_cnt  output  CNT_W  total matches since reset/clear; saturates at all-ones.
- last_gap  output  GAP_W  cycles between the two most recent matches; saturates at all-ones.
- gap_valid  output  1  one-cycle pulse when last_gap updates.
- win_hits  output  CNT_W  matches counted so far in the current window.
- alert  output  1  latched threshold alert.

Behaviour:
- Reset (reset low, asynchronous):
  - match_cnt=0, last_gap=0, gap_valid=0, win_hits=0, alert=0.
  - Window position=0, gap counter=0, first-match flag cleared, state=IDLE.
- State machine: IDLE, RUN, ALERT.
- IDLE:
  - Entered when enable=0, from any state.
  - det_in ignored; all counters held.
  - alert keeps its value; alert_ack still clears it.
  - enable 0->1: go to RUN with window position=0, win_hits=0, first-match flag cleared.
- RUN:
  - Window position increments every cycle.
  - Each det_in=1 increments win_hits and match_cnt.
  - Last window cycle is position WINDOW-1. A pulse on that cycle counts toward the closing window.
  - At the close, if the window total (including that pulse) >= THRESH, go to ALERT and set alert=1 on the next cycle.
  - Otherwise restart the window: position=0, win_hits=0.
- ALERT:
  - Window paused; win_hits frozen at the triggering value.
  - match_cnt and gap measurement continue.
  - alert_ack=1: alert=0 next cycle; return to RUN with a fresh window (position=0, win_hits=0).
  - alert_ack in RUN or IDLE with alert=0: no effect.
- Gap measurement (RUN and ALERT only):
  - Gap counter increments each cycle and saturates at all-ones.
  - On det_in=1:
    - If a previous match has been seen, last_gap <= cycles since that previous pulse (pulses at t and t+3 give 3; back-to-back pulses give 1), saturated to 2^GAP_W-1.
    - gap_valid=1 for exactly one cycle, aligned with the last_gap update.
    - Gap counter restarts.
  - First match after reset, clear, or enable rising gives no gap_valid.
- match_cnt: holds at 2^CNT_W-1 once reached, no wrap.
- win_hits: saturates at 2^CNT_W-1.
- Priority:
  - reset > clear > enable=0 > alert_ack > det_in.
  - clear=1: next cycle all counters, last_gap, win_hits and alert are 0. State becomes RUN if enable=1, else IDLE. A det_in on the clear cycle is dropped.
- Simultaneous alert_ack and window-close threshold hit in the same cycle cannot occur, since the window is paused in ALERT.
- det_in on the same cycle as alert_ack in ALERT still counts toward match_cnt and gap, but not toward the new window.
- Latency: match_cnt, win_hits, last_gap and gap_valid update one cycle after det_in is sampled. alert rises one cycle after the closing window cycle.
- All outputs are registered; no combinational input-to-output paths.

Test Plan:
- Reset mid-run: after 5 matches, pulse reset low asynchronously between edges -> all outputs 0 immediately. First match after release gives match_cnt=1 and no gap_valid.
- Overlapping stream: detector fed 1011011 gives det_in pulses 3 cycles apart -> match_cnt=2, last_gap=3, gap_valid high for one cycle. Back-to-back det_in pulses -> last_gap=1.
- Threshold: WINDOW=8, THRESH=2, pulses at window positions 1 and 7 -> alert=1 the cycle after position 7, win_hits=2 frozen. alert_ack -> alert=0 and win_hits=0 next cycle. With a single pulse in the window -> no alert and window restarts.
- Saturation: CNT_W=4, 20 pulses -> match_cnt stays 15. GAP_W=4, 40 idle cycles then a pulse -> last_gap=15.
- Priority: clear and det_in in the same cycle -> match_cnt=0 next cycle. enable=0 for 10 cycles with det_in pulses -> counters unchanged; re-enable starts a fresh window.
- Alert hold: in ALERT, 3 further pulses -> match_cnt increases by 3, win_hits unchanged, alert stays 1 until alert_ack.

Source files
------------

// File: rtl/seq_det_event_mon.sv
// Purpose : counts 1011-detector match pulses, measures inter-match gaps, raises a latched windowed-threshold alert.
// Latency : counters, last_gap and gap_valid update 1 cycle after det_in; alert rises 1 cycle after the closing window cycle.
// Backpres: none; det_in is always sampled, alert is held until alert_ack.
module seq_det_event_mon #(
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 8,
  parameter int WINDOW = 32,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             det_in,
  input  logic             enable,
  input  logic             clear,
  input  logic             alert_ack,
  output logic [CNT_W-1:0] match_cnt,
  output logic [GAP_W-1:0] last_gap,
  output logic             gap_valid,
  output logic [CNT_W-1:0] win_hits,
  output logic             alert
);

  // Positions run 0..WINDOW-1, so clog2(WINDOW) bits are enough (WINDOW >= 2).
  localparam int                POS_W    = $clog2(WINDOW);
  localparam logic [POS_W-1:0]  POS_LAST = POS_W'(WINDOW - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_ALERT = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   pos_q, pos_d;
  logic [GAP_W-1:0]   gap_ctr_q, gap_ctr_d;
  logic               seen_q, seen_d;
  logic [CNT_W-1:0]   match_cnt_d;
  logic [GAP_W-1:0]   last_gap_d;
  logic               gap_valid_d;
  logic [CNT_W-1:0]   win_hits_d;
  logic               alert_d;
  logic [CNT_W-1:0]   win_total;

  function automatic logic [CNT_W-1:0] sat_cnt(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  function automatic logic [GAP_W-1:0] sat_gap(input logic [GAP_W-1:0] v);
    return (&v) ? v : v + GAP_W'(1);
  endfunction

  // Next-state and datapath: clear beats enable, enable beats alert_ack, alert_ack beats det_in.
  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    gap_ctr_d   = gap_ctr_q;
    seen_d      = seen_q;
    match_cnt_d = match_cnt;
    last_gap_d  = last_gap;
    gap_valid_d = 1'b0;
    win_hits_d  = win_hits;
    alert_d     = alert;
    // Window total including this cycle's pulse, used when closing the window.
    win_total   = det_in ? sat_cnt(win_hits) : win_hits;

    if (clear) begin
      match_cnt_d = '0;
      last_gap_d  = '0;
      win_hits_d  = '0;
      alert_d     = 1'b0;
      pos_d       = '0;
      gap_ctr_d   = '0;
      seen_d      = 1'b0;
      state_d     = enable ? S_RUN : S_IDLE;
    end else if (!enable) begin
      state_d = S_IDLE;
      if (alert_ack) alert_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // Re-enable: fresh window, and the next match starts gap timing anew.
          state_d    = S_RUN;
          pos_d      = '0;
          win_hits_d = '0;
          seen_d     = 1'b0;
          if (alert_ack) alert_d = 1'b0;
        end
        S_RUN: begin
          if (alert_ack) alert_d = 1'b0;
          if (pos_q == POS_LAST) begin
            if (32'(win_total) >= 32'(THRESH)) begin
              state_d    = S_ALERT;
              alert_d    = 1'b1;
              win_hits_d = win_total;
            end else begin
              pos_d      = '0;
              win_hits_d = '0;
            end
          end else begin
            pos_d      = pos_q + POS_W'(1);
            win_hits_d = win_total;
          end
        end
        S_ALERT: begin
          // Window stays paused until acknowledged; a pulse this cycle is not part of the new window.
          if (alert_ack) begin
            alert_d    = 1'b0;
            state_d    = S_RUN;
            pos_d      = '0;
            win_hits_d = '0;
          end
        end
        default: state_d = S_IDLE;
      endcase

      // Total count and gap measurement keep running in RUN and ALERT.
      if (state_q != S_IDLE) begin
        if (det_in) begin
          match_cnt_d = sat_cnt(match_cnt);
          if (seen_q) begin
            last_gap_d  = gap_ctr_q;
            gap_valid_d = 1'b1;
          end
          seen_d    = 1'b1;
          // One cycle will have elapsed when the counter is next sampled.
          gap_ctr_d = GAP_W'(1);
        end else begin
          gap_ctr_d = sat_gap(gap_ctr_q);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      pos_q     <= '0;
      gap_ctr_q <= '0;
      seen_q    <= 1'b0;
      match_cnt <= '0;
      last_gap  <= '0;
      gap_valid <= 1'b0;
      win_hits  <= '0;
      alert     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_q     <= pos_d;
      gap_ctr_q <= gap_ctr_d;
      seen_q    <= seen_d;
      match_cnt <= match_cnt_d;
      last_gap  <= last_gap_d;
      gap_valid <= gap_valid_d;
      win_hits  <= win_hits_d;
      alert     <= alert_d;
    end
  end

endmodule

// File: tb/tb_seq_det_event_mon.sv
// Purpose : scoreboard bench for seq_det_event_mon with a small window and narrow counters.
// Latency : expected outputs are queued when inputs are driven and compared 1 ns after the next rising edge.
// Backpres: none.
module tb_seq_det_event_mon;

  localparam int CNT_W  = 4;
  localparam int GAP_W  = 4;
  localparam int WINDOW = 8;
  localparam int THRESH = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;
  localparam int GMAX   = (1 << GAP_W) - 1;
  localparam int M_IDLE = 0, M_RUN = 1, M_ALERT = 2;

  logic             clk = 1'b0;
  logic             reset, det_in, enable, clear, alert_ack;
  logic [CNT_W-1:0] match_cnt, win_hits;
  logic [GAP_W-1:0] last_gap;
  logic             gap_valid, alert;

  typedef struct {
    int cnt;
    int gap;
    int gv;
    int win;
    int al;
  } exp_t;

  exp_t sb[$];

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  int m_state, m_pos, m_win, m_cnt, m_gapc, m_last, m_seen, m_gv, m_alert;

  seq_det_event_mon #(
    .CNT_W (CNT_W),
    .GAP_W (GAP_W),
    .WINDOW(WINDOW),
    .THRESH(THRESH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .det_in   (det_in),
    .enable   (enable),
    .clear    (clear),
    .alert_ack(alert_ack),
    .match_cnt(match_cnt),
    .last_gap (last_gap),
    .gap_valid(gap_valid),
    .win_hits (win_hits),
    .alert    (alert)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_pos = 0; m_win = 0; m_cnt = 0; m_gapc = 0;
    m_last = 0; m_seen = 0; m_gv = 0; m_alert = 0;
  endtask

  // One clock of the behavioural model, from the currently driven inputs.
  task automatic model_step();
    int total;
    m_gv = 0;
    if (clear) begin
      m_cnt = 0; m_last = 0; m_win = 0; m_alert = 0; m_pos = 0; m_gapc = 0; m_seen = 0;
      m_state = enable ? M_RUN : M_IDLE;
    end else if (!enable) begin
      m_state = M_IDLE;
      if (alert_ack) m_alert = 0;
    end else if (m_state == M_IDLE) begin
      m_state = M_RUN; m_pos = 0; m_win = 0; m_seen = 0;
      if (alert_ack) m_alert = 0;
    end else begin
      if (det_in) begin
        m_cnt = imin(m_cnt + 1, CMAX);
        if (m_seen != 0) begin
          m_last = m_gapc;
          m_gv   = 1;
        end
        m_seen = 1;
        m_gapc = 1;
      end else begin
        m_gapc = imin(m_gapc + 1, GMAX);
      end
      if (m_state == M_ALERT) begin
        if (alert_ack) begin
          m_alert = 0; m_state = M_RUN; m_pos = 0; m_win = 0;
        end
      end else begin
        if (alert_ack) m_alert = 0;
        total = det_in ? imin(m_win + 1, CMAX) : m_win;
        if (m_pos == WINDOW - 1) begin
          if (total >= THRESH) begin
            m_state = M_ALERT; m_alert = 1; m_win = total;
          end else begin
            m_pos = 0; m_win = 0;
          end
        end else begin
          m_pos++;
          m_win = total;
        end
      end
    end
  endtask

  // Drive one cycle: queue the expectation, clock, then compare.
  task automatic cyc(input logic d);
    exp_t e;
    det_in = d;
    model_step();
    e.cnt = m_cnt; e.gap = m_last; e.gv = m_gv; e.win = m_win; e.al = m_alert;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_eq("sb_match_cnt", 32'(match_cnt), e.cnt);
    check_eq("sb_last_gap",  32'(last_gap),  e.gap);
    check_eq("sb_gap_valid", 32'(gap_valid), e.gv);
    check_eq("sb_win_hits",  32'(win_hits),  e.win);
    check_eq("sb_alert",     32'(alert),     e.al);
    det_in    = 1'b0;
    alert_ack = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_cnt"},   32'(match_cnt), 0);
    check_eq({tag, "_gap"},   32'(last_gap),  0);
    check_eq({tag, "_gv"},    32'(gap_valid), 0);
    check_eq({tag, "_win"},   32'(win_hits),  0);
    check_eq({tag, "_alert"}, 32'(alert),     0);
  endtask

  initial begin
    reset = 1'b0; det_in = 1'b0; enable = 1'b0; clear = 1'b0; alert_ack = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Threshold: pulses at window positions 1 and 7.
    enable = 1'b1;
    cyc(1'b0);                 // IDLE -> RUN
    cyc(1'b0);                 // pos 0
    cyc(1'b1);                 // pos 1
    idle_cycles(5);            // pos 2..6
    check_eq("pre_close_alert", 32'(alert), 0);
    cyc(1'b1);                 // pos 7, closes window
    check_eq("thr_alert", 32'(alert), 1);
    check_eq("thr_win",   32'(win_hits), 2);
    check_eq("thr_gap",   32'(last_gap), 6);

    // Alert hold: three more pulses while in ALERT.
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b0); cyc(1'b1);
    idle_cycles(3);
    check_eq("hold_cnt",   32'(match_cnt), 5);
    check_eq("hold_win",   32'(win_hits), 2);
    check_eq("hold_alert", 32'(alert), 1);
    alert_ack = 1'b1;
    cyc(1'b0);
    check_eq("ack_alert", 32'(alert), 0);
    check_eq("ack_win",   32'(win_hits), 0);

    // Single pulse in a full window: no alert, window restarts.
    idle_cycles(3); cyc(1'b1); idle_cycles(4);
    check_eq("single_alert", 32'(alert), 0);
    check_eq("single_win",   32'(win_hits), 0);

    // Clear beats det_in; then pulses 3 apart, then back-to-back.
    clear = 1'b1;
    cyc(1'b1);
    check_eq("clr_cnt",   32'(match_cnt), 0);
    check_eq("clr_alert", 32'(alert), 0);
    cyc(1'b1);
    check_eq("first_gv", 32'(gap_valid), 0);
    cyc(1'b0); cyc(1'b0); cyc(1'b1);
    check_eq("ovl_cnt", 32'(match_cnt), 2);
    check_eq("ovl_gap", 32'(last_gap), 3);
    check_eq("ovl_gv",  32'(gap_valid), 1);
    cyc(1'b0);
    check_eq("ovl_gv_drop", 32'(gap_valid), 0);
    cyc(1'b1); cyc(1'b1);
    check_eq("b2b_gap", 32'(last_gap), 1);
    check_eq("b2b_cnt", 32'(match_cnt), 4);

    // Saturation of match_cnt and of the gap measurement.
    for (int i = 0; i < 20; i++) cyc(1'b1);
    check_eq("sat_cnt", 32'(match_cnt), CMAX);
    idle_cycles(40);
    cyc(1'b1);
    check_eq("sat_gap", 32'(last_gap), GMAX);
    check_eq("sat_gv",  32'(gap_valid), 1);

    // Enable low holds everything despite pulses; re-enable opens a fresh window.
    alert_ack = 1'b1;
    clear     = 1'b1;
    cyc(1'b0);
    cyc(1'b1); cyc(1'b0); cyc(1'b1); cyc(1'b1);
    enable = 1'b0;
    for (int i = 0; i < 10; i++) cyc(i[0]);
    check_eq("dis_cnt", 32'(match_cnt), 3);
    check_eq("dis_gap", 32'(last_gap), 1);
    enable = 1'b1;
    cyc(1'b1);                 // pulse dropped on the re-enable cycle
    check_eq("reen_win", 32'(win_hits), 0);
    check_eq("reen_cnt", 32'(match_cnt), 3);
    cyc(1'b1);
    check_eq("reen_gv", 32'(gap_valid), 0);
    idle_cycles(8);

    // Reset mid-run after five matches, asserted between edges.
    for (int i = 0; i < 5; i++) cyc(1'b1);
    #2 reset = 1'b0;
    #1 check_zero("amid");
    #1 reset = 1'b1;
    model_reset();
    cyc(1'b0);                 // IDLE -> RUN
    cyc(1'b1);
    check_eq("post_rst_cnt", 32'(match_cnt), 1);
    check_eq("post_rst_gv",  32'(gap_valid), 0);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 25) != 0);
      clear     = ($urandom_range(0, 60) == 0);
      alert_ack = ($urandom_range(0, 7) == 0);
      cyc($urandom_range(0, 2) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
